// File: rtl/cart_ram_loader.sv
// Packs cartridge symbols MSB-first into RAM words, with framed loads, partial-word flush and overflow flag.
// Optional: define CART_RAM_LOADER_CHECKSUM_EN to add a running XOR checksum of written words.
module cart_ram_loader #(
  parameter int SYMBOL_W = 2,
  parameter int WORD_W   = 12,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_start,
  input  logic                load_end,
  input  logic                symbol_valid,
  input  logic [SYMBOL_W-1:0] symbol,
  input  logic [ADDR_W-1:0]   read_address,
  output logic [WORD_W-1:0]   read_data,
  output logic                busy,
  output logic                load_done,
  output logic [ADDR_W:0]     words_loaded,
  output logic                overflow
`ifdef CART_RAM_LOADER_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0]   checksum
`endif
);

  localparam int SPW    = WORD_W / SYMBOL_W;
  localparam int CNT_W  = $clog2(SPW + 1);
  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SPW - 1);
  localparam logic [ADDR_W:0]  DEPTH_P  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} stateT;

  stateT             stateReg, stateNext;
  logic [WORD_W-1:0] shiftReg, packedWord, flushWord, emitWord, wrData;
  logic [CNT_W-1:0]  countReg, countAfter;
  logic [ADDR_W:0]   ptrReg;
  logic [RAM_AW-1:0] wrAddr;
  logic              wrValid, accept, wordDone, emit;
  logic [WORD_W-1:0] ram [DEPTH];

  always_comb begin
    accept     = (stateReg == LOAD) && symbol_valid && !load_start;
    wordDone   = accept && (countReg == LAST_CNT);
    countAfter = countReg;
    if (wordDone)
      countAfter = '0;
    else if (accept)
      countAfter = countReg + 1'b1;
    packedWord = {shiftReg[WORD_W-SYMBOL_W-1:0], symbol};
    // Partial word sits in the LSBs; shifting left aligns it and zero-fills the tail.
    flushWord  = shiftReg << (WORD_W - SYMBOL_W * int'(countReg));
    emit       = wordDone || ((stateReg == FLUSH) && !load_start);
    emitWord   = wordDone ? packedWord : flushWord;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stateReg <= IDLE;
    else
      stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:  if (load_start) stateNext = LOAD;
      LOAD: begin
        if (load_start)
          stateNext = LOAD;
        else if (load_end)
          stateNext = (countAfter != '0) ? FLUSH : DONE;
      end
      FLUSH: stateNext = load_start ? LOAD : DONE;
      DONE:  if (load_start) stateNext = LOAD;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy      = (stateReg == LOAD) || (stateReg == FLUSH);
    load_done = (stateReg == DONE);
  end

  // Completed words go through a one-cycle write stage; an abort does not cancel it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shiftReg     <= '0;
      countReg     <= '0;
      ptrReg       <= '0;
      wrValid      <= 1'b0;
      wrAddr       <= '0;
      wrData       <= '0;
      words_loaded <= '0;
      overflow     <= 1'b0;
`ifdef CART_RAM_LOADER_CHECKSUM_EN
      checksum     <= '0;
`endif
    end else begin
      wrValid <= 1'b0;
      if (wrValid) begin
        words_loaded <= words_loaded + 1'b1;
`ifdef CART_RAM_LOADER_CHECKSUM_EN
        checksum     <= checksum ^ wrData;
`endif
      end
      if (load_start) begin
        shiftReg     <= '0;
        countReg     <= '0;
        ptrReg       <= '0;
        words_loaded <= '0;
        overflow     <= 1'b0;
`ifdef CART_RAM_LOADER_CHECKSUM_EN
        checksum     <= '0;
`endif
      end else begin
        if (accept)
          shiftReg <= packedWord;
        countReg <= (stateReg == FLUSH) ? '0 : countAfter;
        if (emit) begin
          if (ptrReg != DEPTH_P) begin
            wrValid <= 1'b1;
            wrAddr  <= ptrReg[RAM_AW-1:0];
            wrData  <= emitWord;
            ptrReg  <= ptrReg + 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wrValid)
      ram[wrAddr] <= wrData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      read_data <= '0;
    else if ({1'b0, read_address} < DEPTH_P)
      read_data <= ram[read_address[RAM_AW-1:0]];
    else
      read_data <= '0;
  end

endmodule

// File: tb/tb_cart_ram_loader.sv
// Randomised and directed bench for cart_ram_loader against a queue-based model of the loader.
module tb_cart_ram_loader;

  localparam int SYMBOL_W = 2;
  localparam int WORD_W   = 12;
  localparam int ADDR_W   = 8;
  localparam int DEPTH    = 4;
  localparam int SPW      = WORD_W / SYMBOL_W;
  localparam int M_IDLE = 0, M_LOAD = 1, M_FLUSH = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic reset, load_start, load_end, symbol_valid;
  logic [SYMBOL_W-1:0] symbol;
  logic [ADDR_W-1:0]   read_address;
  logic [WORD_W-1:0]   read_data;
  logic                busy, load_done, overflow;
  logic [ADDR_W:0]     words_loaded;
`ifdef CART_RAM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0]   checksum;
`endif

  int total = 0;
  int bad = 0;
  bit cmpEn = 0;
  int raSel = 0;

  // model state
  int mMode, mPtr, mWords, mOvf, mPend, mPendAddr, mPendData, mChk, mRd, mRdKnown;
  int mSyms[$];
  int mRam[256];
  bit mValid[256];

  cart_ram_loader #(.SYMBOL_W(SYMBOL_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_end(load_end),
    .symbol_valid(symbol_valid), .symbol(symbol), .read_address(read_address),
    .read_data(read_data), .busy(busy), .load_done(load_done),
    .words_loaded(words_loaded), .overflow(overflow)
`ifdef CART_RAM_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int packSyms();
    int w = 0;
    foreach (mSyms[i]) w |= mSyms[i] << (WORD_W - SYMBOL_W * (i + 1));
    return w;
  endfunction

  task automatic modelEmit(input int w);
    if (mPtr < DEPTH) begin
      mPend = 1; mPendAddr = mPtr; mPendData = w; mPtr++;
    end else begin
      mOvf = 1;
    end
  endtask

  task automatic modelReset();
    mMode = M_IDLE; mSyms.delete(); mPtr = 0; mWords = 0; mOvf = 0;
    mPend = 0; mChk = 0; mRd = 0; mRdKnown = 1;
  endtask

  // One clock edge of the loader, evaluated from the inputs present at that edge.
  task automatic modelStep(input bit ls, input bit le, input bit sv, input int sym, input int ra);
    if (ra < DEPTH) begin
      mRdKnown = mValid[ra]; mRd = mRam[ra];
    end else begin
      mRdKnown = 1; mRd = 0;
    end
    if (mPend != 0) begin
      mRam[mPendAddr] = mPendData; mValid[mPendAddr] = 1;
      mWords++; mChk ^= mPendData; mPend = 0;
    end
    if (ls) begin
      mMode = M_LOAD; mSyms.delete(); mPtr = 0; mWords = 0; mOvf = 0; mChk = 0;
    end else if (mMode == M_LOAD) begin
      if (sv) begin
        mSyms.push_back(sym);
        if (mSyms.size() == SPW) begin
          modelEmit(packSyms());
          mSyms.delete();
        end
      end
      if (le) begin
        mMode = (mSyms.size() > 0) ? M_FLUSH : M_DONE;
        if (mMode == M_DONE) $display("txn load complete ptr=%0d overflow=%0d", mPtr, mOvf);
      end
    end else if (mMode == M_FLUSH) begin
      modelEmit(packSyms());
      mSyms.delete();
      mMode = M_DONE;
      $display("txn load complete (flushed) ptr=%0d overflow=%0d", mPtr, mOvf);
    end
  endtask

  task automatic step(input bit ls, input bit le, input bit sv, input int sym, input int ra);
    load_start = ls; load_end = le; symbol_valid = sv;
    symbol = SYMBOL_W'(sym); read_address = ADDR_W'(ra);
    @(posedge clk);
    modelStep(ls, le, sv, sym, ra);
    #2;
  endtask

  task automatic feedWord(input int w);
    for (int i = 0; i < SPW; i++)
      step(0, 0, 1, (w >> (WORD_W - SYMBOL_W * (i + 1))) & ((1 << SYMBOL_W) - 1), raSel);
  endtask

  always @(negedge clk) begin
    if (cmpEn && !reset) begin
      chk("busy", int'(busy), (mMode == M_LOAD || mMode == M_FLUSH) ? 1 : 0);
      chk("load_done", int'(load_done), (mMode == M_DONE) ? 1 : 0);
      chk("words_loaded", int'(words_loaded), mWords);
      chk("overflow", int'(overflow), mOvf);
      if (mRdKnown != 0) chk("read_data", int'(read_data), mRd);
`ifdef CART_RAM_LOADER_CHECKSUM_EN
      chk("checksum", int'(checksum), mChk);
`endif
    end
  end

  initial begin
    reset = 1; load_start = 0; load_end = 0; symbol_valid = 0; symbol = '0; read_address = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(load_done), 0);
    chk("rst_words", int'(words_loaded), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_rdata", int'(read_data), 0);
    reset = 0;
    cmpEn = 1;

    // full word, no flush
    raSel = 0;
    step(1, 0, 0, 0, 0);
    feedWord('hE4F);
    step(0, 1, 0, 0, 0);
    chk("full_noflush_busy", int'(busy), 0);
    chk("full_done", int'(load_done), 1);
    chk("full_words", int'(words_loaded), 1);
    step(0, 0, 0, 0, 0);
    chk("full_read0", int'(read_data), 'hE4F);

    // partial flush
    step(1, 0, 0, 0, 0);
    feedWord('hE4F);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 2, 0);
    step(0, 1, 0, 0, 0);
    chk("flush_busy", int'(busy), 1);
    chk("flush_notdone", int'(load_done), 0);
    step(0, 0, 0, 0, 0);
    chk("flush_onecycle", int'(busy), 0);
    chk("flush_done", int'(load_done), 1);
    step(0, 0, 0, 0, 1);
    chk("flush_words", int'(words_loaded), 2);
`ifdef CART_RAM_LOADER_CHECKSUM_EN
    chk("flush_checksum", int'(checksum), 'h84F);
`endif
    step(0, 0, 0, 0, 1);
    chk("flush_read1", int'(read_data), 'h600);

    // overflow with DEPTH=4
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) feedWord('h111);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("ovf_words", int'(words_loaded), 4);
    chk("ovf_flag", int'(overflow), 1);
    for (int a = 0; a < 5; a++) begin
      step(0, 0, 0, 0, a);
      chk($sformatf("ovf_read%0d", a), int'(read_data), (a < 4) ? 'h111 : 0);
    end

    // abort mid-word
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0);
    chk("abort_ovf_clr", int'(overflow), 0);
    feedWord('h5A3);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("abort_words", int'(words_loaded), 1);
    chk("abort_read0", int'(read_data), 'h111);
    step(0, 0, 0, 0, 0);
    chk("abort_ram0", int'(read_data), 'h5A3);

    // same-edge read/write collision
    step(1, 0, 0, 0, 0);
    feedWord('hABC);
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    feedWord('h123);
    step(0, 1, 0, 0, 0);
    chk("collide_old", int'(read_data), 'hABC);
    step(0, 0, 0, 0, 0);
    chk("collide_new", int'(read_data), 'h123);

    // asynchronous reset mid-load
    step(1, 0, 0, 0, 0);
    feedWord('h777);
    step(0, 0, 1, 2, 0);
    step(0, 0, 1, 3, 0);
    step(0, 0, 1, 1, 0);
    #1;
    reset = 1;
    modelReset();
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_words", int'(words_loaded), 0);
    chk("arst_rdata", int'(read_data), 0);
    @(negedge clk);
    #1;
    reset = 0;
    step(0, 0, 0, 0, 0);
    chk("arst_keep_ram", int'(read_data), 'h777);

    // randomised traffic
    for (int c = 0; c < 1500; c++) begin
      bit ls, le, sv;
      ls = (mMode == M_IDLE || mMode == M_DONE) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 79) == 0);
      le = (mMode == M_LOAD) && ($urandom_range(0, 20) == 0);
      sv = ($urandom_range(0, 3) != 0);
      step(ls, le, sv, $urandom_range(0, 3), $urandom_range(0, 7));
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    cmpEn = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cart_ram_loader.md
Name: cart_ram_loader

Overview:
Parametrised program-memory loader for symbols read from the RGBY-ROM data cartridge. It packs SYMBOL_W-bit symbols MSB-first into WORD_W-bit words and writes each word to internal RAM at an incrementing address. It adds framed loads (start/end), zero-padded flush of a partial final word, a word count, and overflow detection. A synchronous read port feeds the CPU fetch path.

Parameters:
SYMBOL_W, 2, bits per cartridge symbol (colour); must divide WORD_W
WORD_W, 12, RAM word width
ADDR_W, 8, RAM address width
DEPTH, 256, words of RAM; DEPTH <= 2**ADDR_W

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-high; clears all state except RAM contents
load_start  in  1  pulse: begin new load, clear pointer/count/flags
load_end  in  1  pulse: end of cartridge data
symbol_valid  in  1  symbol qualifier, one symbol per asserted cycle
symbol  in  SYMBOL_W  cartridge symbol
read_address  in  ADDR_W  fetch address
read_data  out  WORD_W  RAM word, registered
busy  out  1  high in LOAD and FLUSH
load_done  out  1  sticky high in DONE
words_loaded  out  ADDR_W+1  words written this load
overflow  out  1  sticky: a completed word was dropped because RAM was full

Behaviour:
- Reset values: read_data 0, busy 0, load_done 0, words_loaded 0, overflow 0, state IDLE, shift register 0, symbol count 0, write pointer 0.
- SPW = WORD_W/SYMBOL_W symbols per word. Count width is clog2(SPW+1).
- States:
  - IDLE: load_start -> LOAD.
  - LOAD: load_end -> FLUSH if symbol count > 0 after this cycle's symbol, else DONE.
  - FLUSH: one cycle, then DONE.
  - DONE: load_start -> LOAD.
- symbol_valid is honoured only in LOAD. In any other state it is ignored.
- Packing: shift <= {shift[WORD_W-SYMBOL_W-1:0], symbol}, and count increments. The first symbol lands in the MSBs.
- When the SPW-th symbol is accepted:
  - The completed word and write pointer are registered into a write stage.
  - The RAM write occurs on the following edge.
  - words_loaded increments on that same write edge.
  - The count returns to 0 in the accepting cycle, so back-to-back symbols are accepted with no stall.
- FLUSH: the partial word is left-aligned, with the remaining (SPW-count)*SYMBOL_W LSBs zero. It is written like a full word.
- Write pointer: increments per word written. When pointer == DEPTH, completed words are not written, words_loaded holds, and overflow sets (sticky until load_start or reset). No wrap-around.
- symbol_valid and load_end in the same cycle: the symbol is accepted first, then end processing uses the updated count.
- load_start in LOAD or FLUSH: abort. Discard the partial word, clear pointer, count, words_loaded, overflow and load_done, and stay in or enter LOAD. An in-flight write-stage word still commits.
- load_start and load_end together: load_start wins.
- Read port: read_data <= ram[read_address] on every edge, giving 1-cycle latency.
  - Same-address read and write on the same edge returns old data (read-before-write).
  - read_address >= DEPTH returns 0.
- Reset mid-load: the state machine returns to IDLE immediately and asynchronously, and a pending write is cancelled. RAM contents are preserved.
- load_done is set on entry to DONE and cleared by load_start.

Optional Feature:
Macro CART_RAM_LOADER_CHECKSUM_EN.
- Defined: adds output checksum [WORD_W-1:0], the running XOR of every word actually written to RAM. It is cleared by reset and load_start, and updates on the write edge. Dropped (overflow) words are excluded.
- Undefined: no checksum port or logic. All other behaviour is identical.

Test Plan:
- Full word: load_start; symbols 3,2,1,0,3,3 on consecutive cycles; load_end -> ram[0]=0xE4F, words_loaded=1, DONE with no FLUSH, read_address=0 gives read_data=0xE4F one cycle later.
- Partial flush: continue a second load of 0xE4F followed by symbols 1,2 then load_end -> ram[1]=0x600, words_loaded=2, FLUSH lasts exactly 1 cycle, load_done=1; with the macro defined, checksum=0x84F.
- Overflow: DEPTH=4; 5 full words of 0x111 -> words_loaded=4, overflow=1, 5th word not written, ram[0..3]=0x111.
- Abort: load_start after 3 symbols of a word -> count and pointer clear; next 6 symbols write ram[0]; the partial word is never written.
- Same-edge collision: read ram[0] (old 0xABC) on the edge that writes 0x123 -> read_data=0xABC, then 0x123 on the next read.
- Async reset mid-load: assert reset between clock edges -> busy=0 and words_loaded=0 immediately; previously written RAM words are still readable after release.
